// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core constants and types
package mips_pkg;

    localparam int unsigned WORD_WIDTH = 32;

    localparam logic [WORD_WIDTH-1:0] NOP_INST         = 32'h0000_0000;
    localparam logic [WORD_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [WORD_WIDTH-1:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

    // Opcode / funct values ID decodes to generate redirect requests
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_JALR = 6'h09;

endpackage

// File: rtl/if_halt_detect.sv
// rtl/if_halt_detect.sv - zero-word run counter with sticky end-of-program flag
module if_halt_detect #(
    parameter int unsigned HALT_COUNT = 10
) (
    input  logic clk,
    input  logic nrst,
    input  logic advance,
    input  logic inst_is_zero,
    output logic halted
);

    localparam logic [7:0] HALT_LIMIT = 8'(HALT_COUNT);

    logic [7:0] zero_cnt;

    // Once halted, advance drops, so the counter stays parked at the limit.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            zero_cnt <= 8'd0;
            halted   <= 1'b0;
        end else if (advance) begin
            if (inst_is_zero) begin
                if (zero_cnt >= HALT_LIMIT - 8'd1) begin
                    zero_cnt <= HALT_LIMIT;
                    halted   <= 1'b1;
                end else begin
                    zero_cnt <= zero_cnt + 8'd1;
                end
            end else begin
                zero_cnt <= 8'd0;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: PC register, IF/ID register, redirect and halt handling
module if_stage
    import mips_pkg::*;
#(
    parameter logic [WORD_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter bit                    DELAY_SLOT = 1'b1,
    parameter int unsigned           HALT_COUNT = 10
) (
    input  logic                  clk,
    input  logic                  nrst,
    output logic [WORD_WIDTH-1:0] inst_addr,
    input  logic [WORD_WIDTH-1:0] inst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  redirect_en,
    input  logic [WORD_WIDTH-1:0] redirect_addr,
    output logic [WORD_WIDTH-1:0] id_inst,
    output logic [WORD_WIDTH-1:0] id_pc4,
    output logic                  id_valid,
    output logic [WORD_WIDTH-1:0] pc_IF,
    output logic [WORD_WIDTH-1:0] pc_ID,
    output logic                  halted
);

    logic [WORD_WIDTH-1:0] pc;
    logic [WORD_WIDTH-1:0] pc_plus4;
    logic [WORD_WIDTH-1:0] pc_next;
    logic                  squash;
    logic                  advance;

    assign pc_plus4 = pc + 32'd4;
    assign pc_next  = redirect_en ? (redirect_addr & PC_ALIGN_MASK) : pc_plus4;
    // Without a delay slot the word fetched beside a redirect is on the wrong path
    assign squash   = flush | (redirect_en & (DELAY_SLOT == 1'b0));
    assign advance  = !stall && !halted;

    assign inst_addr = pc;
    assign pc_IF     = pc;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pc       <= RESET_PC;
            id_inst  <= NOP_INST;
            id_pc4   <= RESET_PC + 32'd4;
            pc_ID    <= RESET_PC;
            id_valid <= 1'b0;
        end else if (halted) begin
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else if (!stall) begin
            pc     <= pc_next;
            pc_ID  <= pc;
            id_pc4 <= pc_plus4;
            if (squash) begin
                id_inst  <= NOP_INST;
                id_valid <= 1'b0;
            end else begin
                id_inst  <= inst;
                id_valid <= 1'b1;
            end
        end
    end

    if_halt_detect #(
        .HALT_COUNT(HALT_COUNT)
    ) u_halt_detect (
        .clk         (clk),
        .nrst        (nrst),
        .advance     (advance),
        .inst_is_zero(inst == NOP_INST),
        .halted      (halted)
    );

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized self-checking bench for if_stage against a behavioural model
module tb_if_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] id_inst;
        logic [31:0] id_pc4;
        logic [31:0] pc_id;
        logic        valid;
        logic        halted;
        int          run;
    } mstate_t;

    logic        clk;
    logic        nrst;
    logic        stall;
    logic        flush;
    logic        redirect_en;
    logic [31:0] redirect_addr;

    logic [31:0] addr    [3];
    logic [31:0] inst    [3];
    logic [31:0] id_inst [3];
    logic [31:0] id_pc4  [3];
    logic [31:0] pcif    [3];
    logic [31:0] pcid    [3];
    logic        idv     [3];
    logic        hlt     [3];

    logic [31:0] mem [64];
    mstate_t     m   [3];

    localparam bit          DS [3] = '{1'b1, 1'b0, 1'b1};
    localparam logic [31:0] RP [3] = '{32'h0, 32'h0, 32'hFFFF_FFF8};

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign inst[0] = mem[addr[0][7:2]];
    assign inst[1] = mem[addr[1][7:2]];
    assign inst[2] = mem[addr[2][7:2]];

    if_stage #(.RESET_PC(32'h0), .DELAY_SLOT(1'b1), .HALT_COUNT(10)) u_ds (
        .clk(clk), .nrst(nrst), .inst_addr(addr[0]), .inst(inst[0]), .stall(stall),
        .flush(flush), .redirect_en(redirect_en), .redirect_addr(redirect_addr),
        .id_inst(id_inst[0]), .id_pc4(id_pc4[0]), .id_valid(idv[0]), .pc_IF(pcif[0]),
        .pc_ID(pcid[0]), .halted(hlt[0]));

    if_stage #(.RESET_PC(32'h0), .DELAY_SLOT(1'b0), .HALT_COUNT(10)) u_nods (
        .clk(clk), .nrst(nrst), .inst_addr(addr[1]), .inst(inst[1]), .stall(stall),
        .flush(flush), .redirect_en(redirect_en), .redirect_addr(redirect_addr),
        .id_inst(id_inst[1]), .id_pc4(id_pc4[1]), .id_valid(idv[1]), .pc_IF(pcif[1]),
        .pc_ID(pcid[1]), .halted(hlt[1]));

    if_stage #(.RESET_PC(32'hFFFF_FFF8), .DELAY_SLOT(1'b1), .HALT_COUNT(10)) u_wrap (
        .clk(clk), .nrst(nrst), .inst_addr(addr[2]), .inst(inst[2]), .stall(stall),
        .flush(flush), .redirect_en(redirect_en), .redirect_addr(redirect_addr),
        .id_inst(id_inst[2]), .id_pc4(id_pc4[2]), .id_valid(idv[2]), .pc_IF(pcif[2]),
        .pc_ID(pcid[2]), .halted(hlt[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic mstate_t model_reset(input logic [31:0] rpc);
        mstate_t s;
        s.pc = rpc; s.id_inst = 32'h0; s.id_pc4 = rpc + 32'd4; s.pc_id = rpc;
        s.valid = 1'b0; s.halted = 1'b0; s.run = 0;
        return s;
    endfunction

    function automatic mstate_t model_step(input mstate_t s, input bit ds, input bit st,
                                           input bit fl, input bit re,
                                           input logic [31:0] ra, input logic [31:0] w);
        mstate_t n;
        n = s;
        if (s.halted) begin
            n.id_inst = 32'h0;
            n.valid   = 1'b0;
        end else if (!st) begin
            n.pc    = re ? (ra - (ra % 4)) : s.pc + 32'd4;
            n.pc_id = s.pc;
            n.id_pc4 = s.pc + 32'd4;
            if (fl || (re && !ds)) begin
                n.id_inst = 32'h0;
                n.valid   = 1'b0;
            end else begin
                n.id_inst = w;
                n.valid   = 1'b1;
            end
            n.run = (w == 32'h0) ? s.run + 1 : 0;
            if (n.run >= 10) n.halted = 1'b1;
        end
        return n;
    endfunction

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("u%0d.inst_addr", k), addr[k], m[k].pc);
            check($sformatf("u%0d.pc_IF", k), pcif[k], m[k].pc);
            check($sformatf("u%0d.id_inst", k), id_inst[k], m[k].id_inst);
            check($sformatf("u%0d.id_pc4", k), id_pc4[k], m[k].id_pc4);
            check($sformatf("u%0d.pc_ID", k), pcid[k], m[k].pc_id);
            check($sformatf("u%0d.id_valid", k), 32'(idv[k]), 32'(m[k].valid));
            check($sformatf("u%0d.halted", k), 32'(hlt[k]), 32'(m[k].halted));
        end
    endtask

    // Entered and left on a falling edge; inputs are set away from the active edge
    task automatic cycle(input bit st, input bit fl, input bit re, input logic [31:0] ra);
        stall = st; flush = fl; redirect_en = re; redirect_addr = ra;
        @(posedge clk);
        for (int k = 0; k < 3; k++)
            m[k] = model_step(m[k], DS[k], st, fl, re, ra, mem[m[k].pc[7:2]]);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        nrst = 1'b0;
        stall = 1'b0; flush = 1'b0; redirect_en = 1'b0; redirect_addr = 32'h0;
        for (int k = 0; k < 3; k++) m[k] = model_reset(RP[k]);
        #1;
        compare_all();
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        compare_all();
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 64; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1);
    endtask

    initial begin
        nrst = 1'b0;
        stall = 1'b0; flush = 1'b0; redirect_en = 1'b0; redirect_addr = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h1;
        for (int k = 0; k < 3; k++) m[k] = model_reset(RP[k]);

        do_reset();
        check("rst.pc", addr[0], 32'h0);
        check("rst.valid", 32'(idv[0]), 32'h0);
        check("rst.wrap_pc", addr[2], 32'hFFFF_FFF8);
        check("rst.wrap_pc4", id_pc4[2], 32'hFFFF_FFFC);

        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            check("seq.addr", addr[0], 32'(4 * i));
            check("seq.inst", id_inst[0], mem[i - 1]);
            check("seq.pc_ID", pcid[0], 32'(4 * (i - 1)));
            if (i == 1) check("wrap.addr1", addr[2], 32'hFFFF_FFFC);
            if (i == 2) begin
                check("wrap.addr2", addr[2], 32'h0);
                check("wrap.pc_ID", pcid[2], 32'hFFFF_FFFC);
                check("wrap.pc4", id_pc4[2], 32'h0);
            end
        end

        cycle(1'b0, 1'b0, 1'b1, 32'h43);
        check("redir.misalign", addr[0], 32'h40);
        check("redir.ds_inst", id_inst[0], mem[4]);
        check("redir.ds_valid", 32'(idv[0]), 32'h1);
        check("redir.nods_valid", 32'(idv[1]), 32'h0);
        check("redir.nods_inst", id_inst[1], 32'h0);

        cycle(1'b1, 1'b0, 1'b1, 32'h80);
        check("stall.redir", addr[0], 32'h40);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("flush.valid", 32'(idv[0]), 32'h0);
        check("flush.pc_ID", pcid[0], 32'h40);

        fill_mem();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            cycle($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 5) == 0, $urandom);
        end

        for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h1;
        for (int i = 0; i < 20; i++) mem[i] = 32'h0;
        mem[9] = 32'h0000_1234;
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            if (i == 19) check("halt.before", 32'(hlt[0]), 32'h0);
            if (i == 20) check("halt.rise", 32'(hlt[0]), 32'h1);
        end
        for (int i = 0; i < 3; i++) begin
            cycle($urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0, 1'b1, $urandom);
            check("halt.frozen", addr[0], 32'h50);
            check("halt.valid", 32'(idv[0]), 32'h0);
        end
        do_reset();
        check("halt.cleared", 32'(hlt[0]), 32'h0);
        check("halt.pc", addr[0], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage pipelined MIPS core, directly upstream of the decode/forwarding logic.
- Owns the program counter and drives the instruction-memory address.
- Captures the returned instruction into the IF/ID pipeline register.
- Applies stall, flush and branch/jump redirect requests from ID.
- Detects end-of-program: a run of all-zero instruction words.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
DELAY_SLOT, 1, 1 = instruction fetched alongside a redirect is kept (MIPS delay slot); 0 = it is squashed.
HALT_COUNT, 10, consecutive fetched 32'h0 words that cause halt (1..255).

Ports:
clk  in  1  clock; all state updates on rising edge.
nrst  in  1  asynchronous active-low reset.
inst_addr  out  32  PC sent to instruction memory.
inst  in  32  instruction word for inst_addr; combinational, valid in the same cycle.
stall  in  1  hazard unit: hold PC and IF/ID.
flush  in  1  squash IF/ID contents at next edge.
redirect_en  in  1  branch taken / jump resolved in ID.
redirect_addr  in  32  target PC.
id_inst  out  32  IF/ID instruction.
id_pc4  out  32  IF/ID PC+4, for branch target and jal link.
id_valid  out  1  IF/ID holds a real instruction.
pc_IF  out  32  equals inst_addr.
pc_ID  out  32  PC of the instruction in IF/ID.
halted  out  1  sticky end-of-program flag.

Behaviour:
- Reset (nrst=0, asynchronous, any cycle including mid-stall or mid-count):
  - PC=RESET_PC, id_inst=32'h0, id_pc4=RESET_PC+4, pc_ID=RESET_PC, id_valid=0.
  - Halt counter=0, halted=0.
- Latency: inst is captured into IF/ID at the first rising edge after inst_addr is presented, i.e. one cycle IF->ID.
- Per-edge priority, highest first:
  1. halted=1: PC holds; IF/ID loads NOP (id_inst=0, id_valid=0); pc_ID and id_pc4 hold.
  2. stall=1: PC and all IF/ID fields hold; redirect_en and flush are ignored; halt counter holds.
  3. redirect_en=1:
     - PC <= {redirect_addr[31:2],2'b00}.
     - DELAY_SLOT=1: IF/ID captures inst normally, unless flush=1.
     - DELAY_SLOT=0: IF/ID loads NOP.
  4. Otherwise: PC <= PC+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- IF/ID capture when not stalled and not halted:
  - Normal: id_inst=inst, pc_ID=PC, id_pc4=PC+4 (mod 2^32), id_valid=1.
  - flush=1 (with or without redirect): id_inst=0, id_valid=0; pc_ID and id_pc4 still update.
- Halt detector: counter is 8 bits wide and evaluated only on non-stalled, non-halted edges.
  - inst==32'h0: counter increments.
  - Otherwise: counter clears to 0.
  - Counter reaching HALT_COUNT: halted=1 at that same edge; the counter saturates.
  - halted is cleared only by reset.
  - The all-zero words themselves are still captured into IF/ID as valid NOPs (sll $0) until halt.
- Simultaneous redirect_en and stall: stall wins. The ID-stage requester must re-assert redirect on the first unstalled cycle.
- Misaligned redirect_addr: the low two bits are forced to zero; no error is flagged.

Decomposition:
- Shared package mips_pkg:
  - WORD_WIDTH=32.
  - NOP_INST=32'h0000_0000.
  - Default RESET_PC.
  - Opcode constants used by ID for redirect generation.
- One sub-module, if_halt_detect: the zero-run counter plus sticky halted flag.
  - Inputs: clk, nrst, advance, inst_is_zero.
  - Output: halted.
- PC register and IF/ID register stay in if_stage.

Test Plan:
1. Reset/sequential: assert nrst=0 mid-cycle, release; no stall or redirect -> inst_addr 0,4,8,C on successive cycles; id_inst equals memory word at PC-4 with id_valid=1 from the second edge; pc_ID trails pc_IF by one cycle.
2. Stall: stall=1 for 3 cycles at PC=0x10 -> inst_addr stays 0x10, id_inst/pc_ID frozen at 0x0C's data; resumes at 0x14 after release.
3. Redirect with delay slot (DELAY_SLOT=1): redirect_en=1, redirect_addr=0x40 while PC=0x18 -> next inst_addr=0x40, id_inst=word@0x18, id_valid=1. Repeat with DELAY_SLOT=0 -> id_inst=0, id_valid=0. Repeat with stall=1 simultaneously -> PC stays 0x18.
4. Flush and misalignment: flush=1 at PC=0x20 -> id_valid=0, id_inst=0, pc_ID=0x20. redirect_addr=0x43 -> inst_addr=0x40.
5. Halt: feed 9 zero words, one nonzero, then 10 zeros -> halted rises exactly on the 10th consecutive zero's edge; then inst_addr frozen, id_valid=0; nrst pulse clears halted and PC=0.
6. Wrap: RESET_PC=32'hFFFF_FFF8 -> inst_addr FFFF_FFF8, FFFF_FFFC, 0000_0000; id_pc4 for FFFF_FFFC equals 0.
